csa_accumulate_controller: RTL and testbench

//  Sequences a single row of 3:2 compressors to sum a variable-length stream of operands
//  in carry-save form, one operand per cycle. On the last operand it resolves sum/carry
//  by iterating the same compressor row with a zero third input. The result is then

---
 rtl/csa_accumulate_controller.sv | 173 +++++++++++++++++
 tb/tb_csa_accumulate_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accumulate_controller.sv
// csa_accumulate_controller: carry-save accumulator for a stream of unsigned operands.
// One 3:2 compressor row absorbs one operand per cycle; after the last operand the
// same row is iterated with a zero third input until the carry vector is empty, then
// the sum is offered on a valid/ready output.
// Optional build macro: CSA_ACC_OVERFLOW_EN adds a sticky o_overflow result flag.
module csa_accumulate_controller #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH = WIDTH + CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [WIDTH-1:0]     i_in_data,
  input  logic                 i_in_last,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [ACC_WIDTH-1:0] o_out_data,
  output logic [CNT_WIDTH-1:0] o_out_count,
  output logic                 o_busy
`ifdef CSA_ACC_OVERFLOW_EN
  ,
  output logic                 o_overflow
`endif
);

  localparam int unsigned ACC_MSB = ACC_WIDTH - 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_RESOLVE = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ACC_WIDTH-1:0]  r_sum;
  logic [ACC_WIDTH-1:0]  r_cry;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [ACC_WIDTH-1:0]  w_sum_nxt;
  logic [ACC_WIDTH-1:0]  w_cry_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [ACC_WIDTH-1:0]  w_y;
  logic [ACC_WIDTH-1:0]  w_z;
  logic [ACC_WIDTH-1:0]  w_cmp_sum;
  logic [ACC_WIDTH-1:0]  w_cmp_cry;
  logic                  w_accept;
  logic                  w_first;
  logic                  w_drop;
  logic                  w_load_out;
  logic                  w_clr_out;

  // Compressor row: carry vector shifted up one weight, its top bit falls off the end
  always_comb begin
    w_y       = {r_cry[ACC_MSB-1:0], 1'b0};
    w_z       = (r_state == S_ACCUM) ? ACC_WIDTH'(i_in_data) : '0;
    w_cmp_sum = r_sum ^ w_y ^ w_z;
    w_cmp_cry = (r_sum & w_y) | (r_sum & w_z) | (w_y & w_z);
    w_accept  = i_in_valid & o_in_ready;
  end

  // Next-state and datapath update selection
  always_comb begin
    w_state_nxt = r_state;
    w_sum_nxt   = r_sum;
    w_cry_nxt   = r_cry;
    w_cnt_nxt   = r_cnt;
    w_first     = 1'b0;
    w_drop      = 1'b0;
    w_load_out  = 1'b0;
    w_clr_out   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_sum_nxt   = ACC_WIDTH'(i_in_data);
          w_cry_nxt   = '0;
          w_cnt_nxt   = CNT_WIDTH'(1);
          w_first     = 1'b1;
          w_state_nxt = i_in_last ? S_RESOLVE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          w_sum_nxt = w_cmp_sum;
          w_cry_nxt = w_cmp_cry;
          w_drop    = r_cry[ACC_MSB];
          w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_WIDTH'(1);
          if (i_in_last) begin
            w_state_nxt = S_RESOLVE;
          end
        end
      end
      S_RESOLVE: begin
        if (r_cry != '0) begin
          w_sum_nxt = w_cmp_sum;
          w_cry_nxt = w_cmp_cry;
          w_drop    = r_cry[ACC_MSB];
        end else begin
          w_load_out  = 1'b1;
          w_state_nxt = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (i_out_ready) begin
          w_clr_out   = 1'b1;
          w_sum_nxt   = '0;
          w_cry_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, accumulator and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sum       <= '0;
      r_cry       <= '0;
      r_cnt       <= '0;
      o_in_ready  <= 1'b1;
      o_busy      <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sum      <= w_sum_nxt;
      r_cry      <= w_cry_nxt;
      r_cnt      <= w_cnt_nxt;
      o_in_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_ACCUM);
      o_busy     <= (w_state_nxt != S_IDLE);
      if (w_load_out) begin
        o_out_valid <= 1'b1;
        o_out_data  <= r_sum;
        o_out_count <= r_cnt;
      end else if (w_clr_out) begin
        o_out_valid <= 1'b0;
      end
    end
  end

`ifdef CSA_ACC_OVERFLOW_EN
  logic r_ovf;

  // Sticky record of any carry bit dropped off the top during this set
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf      <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (w_first || w_clr_out) begin
        r_ovf <= 1'b0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
      end
      if (w_load_out) begin
        o_overflow <= r_ovf;
      end else if (w_clr_out) begin
        o_overflow <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_csa_accumulate_controller.sv
// Testbench for csa_accumulate_controller: a 16-bit accumulator instance and an
// 8-bit/4-bit-count instance (wrap and count saturation), both checked against
// plain-arithmetic expectations. Build with CSA_ACC_OVERFLOW_EN to check o_overflow.
module tb_csa_accumulate_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_last;
  logic [7:0] in_data;
  logic       out_ready;
  logic       sel;

  logic        in_valid_a, out_ready_a, rdy_a, ov_a, busy_a;
  logic [15:0] data_a;
  logic [7:0]  cnt_a;
  logic        in_valid_b, out_ready_b, rdy_b, ov_b, busy_b;
  logic [7:0]  data_b;
  logic [3:0]  cnt_b;

  logic        w_rdy, w_ov, w_busy;
  logic [15:0] w_data;
  logic [7:0]  w_cnt;

  int checks   = 0;
  int failures = 0;
  bit stuck    = 1'b0;

  always #5 clk = ~clk;

  assign in_valid_a  = in_valid & ~sel;
  assign in_valid_b  = in_valid & sel;
  assign out_ready_a = out_ready & ~sel;
  assign out_ready_b = out_ready & sel;
  assign w_rdy  = sel ? rdy_b  : rdy_a;
  assign w_ov   = sel ? ov_b   : ov_a;
  assign w_busy = sel ? busy_b : busy_a;
  assign w_data = sel ? {8'h00, data_b} : data_a;
  assign w_cnt  = sel ? {4'h0, cnt_b} : cnt_a;

`ifdef CSA_ACC_OVERFLOW_EN
  logic ovf_a, ovf_b, w_ovf;
  assign w_ovf = sel ? ovf_b : ovf_a;
`endif

  csa_accumulate_controller #(.WIDTH(8), .CNT_WIDTH(8), .ACC_WIDTH(16)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (in_valid_a),
    .o_in_ready  (rdy_a),
    .i_in_data   (in_data),
    .i_in_last   (in_last),
    .o_out_valid (ov_a),
    .i_out_ready (out_ready_a),
    .o_out_data  (data_a),
    .o_out_count (cnt_a),
    .o_busy      (busy_a)
`ifdef CSA_ACC_OVERFLOW_EN
    ,
    .o_overflow  (ovf_a)
`endif
  );

  csa_accumulate_controller #(.WIDTH(8), .CNT_WIDTH(4), .ACC_WIDTH(8)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (in_valid_b),
    .o_in_ready  (rdy_b),
    .i_in_data   (in_data),
    .i_in_last   (in_last),
    .o_out_valid (ov_b),
    .i_out_ready (out_ready_b),
    .o_out_data  (data_b),
    .o_out_count (cnt_b),
    .o_busy      (busy_b)
`ifdef CSA_ACC_OVERFLOW_EN
    ,
    .o_overflow  (ovf_b)
`endif
  );

  typedef struct {
    bit          s;
    int          n;
    logic [7:0]  ops [6];
    logic [15:0] ed;
    logic [7:0]  ec;
    logic        eo;
    int          hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the set's value is the plain integer sum; count saturates at 2^cntw-1
  task automatic model(input logic [7:0] ops[$], input int accw, input int cntw,
                       output logic [15:0] d, output logic [7:0] c, output logic o);
    longint s = 0;
    longint lim;
    longint cmax;
    foreach (ops[i]) s += longint'(ops[i]);
    lim  = longint'(1) << accw;
    cmax = (longint'(1) << cntw) - 1;
    d = 16'(s % lim);
    c = 8'((longint'(ops.size()) > cmax) ? cmax : longint'(ops.size()));
    o = (s >= lim);
  endtask

  // Present one beat at a negedge, complete on the accepting edge, return at next negedge
  task automatic send_beat(input logic [7:0] d, input logic last);
    int n = 0;
    if (stuck) return;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!w_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(w_rdy), 32'd1);
    if (!w_rdy) begin
      stuck    = 1'b1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_set(input bit s, input logic [7:0] ops[$], input logic [15:0] ed,
                         input logic [7:0] ec, input logic eo, input int hold,
                         input int gapmax, input string name);
    int n;
    int accw;
    if (stuck) return;
    sel       = s;
    out_ready = 1'b0;
    #1;
    accw = s ? 8 : 16;
    foreach (ops[i]) begin
      if (gapmax > 0) repeat ($urandom_range(gapmax, 0)) @(negedge clk);
      send_beat(ops[i], (i == ops.size() - 1));
    end
    if (stuck) return;
    n = 0;
    while (!w_ov && n < 40) begin
      chk({name, "_resolve_rdy_busy"}, 32'({w_rdy, w_busy}), 32'b01);
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, 32'(w_ov), 32'd1);
    if (!w_ov) begin
      stuck = 1'b1;
      return;
    end
    checks++;
    if (n < 1 || n > accw + 1) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles, allowed 1..%0d", name, n, accw + 1);
    end
    if (ops.size() == 1) chk({name, "_single_latency"}, 32'(n), 32'd1);
    repeat (hold) begin
      chk({name, "_hold_valid"}, 32'(w_ov), 32'd1);
      chk({name, "_hold_data"}, 32'(w_data), 32'(ed));
      chk({name, "_hold_rdy"}, 32'(w_rdy), 32'd0);
      @(negedge clk);
    end
    chk({name, "_data"}, 32'(w_data), 32'(ed));
    chk({name, "_count"}, 32'(w_cnt), 32'(ec));
`ifdef CSA_ACC_OVERFLOW_EN
    chk({name, "_overflow"}, 32'(w_ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unknown overflow expectation");
`endif
    chk({name, "_rdy_before_hs"}, 32'(w_rdy), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_post_hs"}, 32'({w_ov, w_rdy, w_busy}), 32'b010);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vec_t        tbl [10];
    logic [7:0]  q [$];
    logic [15:0] ed;
    logic [7:0]  ec;
    logic        eo;

    tbl[0] = '{1'b0, 3, '{8'd3, 8'd5, 8'd7, 8'd0, 8'd0, 8'd0}, 16'd15, 8'd3, 1'b0, 0};
    tbl[1] = '{1'b0, 1, '{8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 16'd255, 8'd1, 1'b0, 0};
    tbl[2] = '{1'b0, 2, '{8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0}, 16'd3, 8'd2, 1'b0, 5};
    tbl[3] = '{1'b0, 6, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 16'd1530, 8'd6, 1'b0, 1};
    tbl[4] = '{1'b0, 2, '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 16'd0, 8'd2, 1'b0, 0};
    tbl[5] = '{1'b1, 2, '{8'd200, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0}, 16'd44, 8'd2, 1'b1, 0};
    tbl[6] = '{1'b1, 2, '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0}, 16'd2, 8'd2, 1'b0, 0};
    tbl[7] = '{1'b1, 2, '{8'd128, 8'd128, 8'd0, 8'd0, 8'd0, 8'd0}, 16'd0, 8'd2, 1'b1, 2};
    tbl[8] = '{1'b1, 3, '{8'd255, 8'd1, 8'd255, 8'd0, 8'd0, 8'd0}, 16'd255, 8'd3, 1'b1, 0};
    tbl[9] = '{1'b1, 6, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 16'd250, 8'd6, 1'b1, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    sel       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("reset_in_ready", 32'(w_rdy), 32'd1);
      chk("reset_out_valid", 32'(w_ov), 32'd0);
      chk("reset_busy", 32'(w_busy), 32'd0);
      chk("reset_out_data", 32'(w_data), 32'd0);
      chk("reset_out_count", 32'(w_cnt), 32'd0);
    end
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      q = {};
      for (int j = 0; j < tbl[i].n; j++) q.push_back(tbl[i].ops[j]);
      run_set(tbl[i].s, q, tbl[i].ed, tbl[i].ec, tbl[i].eo, tbl[i].hold, 0,
              $sformatf("vec%0d", i));
    end

    // Reset in the middle of a set aborts it
    sel = 1'b0;
    #1;
    send_beat(8'd9, 1'b0);
    send_beat(8'd9, 1'b0);
    chk("midset_rdy_busy", 32'({w_rdy, w_busy}), 32'b11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      chk("abort_idle", 32'({w_ov, w_rdy, w_busy}), 32'b010);
      @(negedge clk);
    end
    q = {8'd4};
    run_set(1'b0, q, 16'd4, 8'd1, 1'b0, 0, 0, "after_rst");

    // Random sets on the wide instance
    for (int k = 0; k < 30; k++) begin
      q = {};
      repeat ($urandom_range(12, 1)) q.push_back(8'($urandom_range(255, 0)));
      model(q, 16, 8, ed, ec, eo);
      run_set(1'b0, q, ed, ec, eo, int'($urandom_range(3, 0)), 2, $sformatf("rand_a%0d", k));
    end

    // Random sets on the narrow instance: wrap and count saturation
    for (int k = 0; k < 15; k++) begin
      q = {};
      repeat ($urandom_range(20, 1)) q.push_back(8'($urandom_range(255, 0)));
      model(q, 8, 4, ed, ec, eo);
      run_set(1'b1, q, ed, ec, eo, int'($urandom_range(3, 0)), 2, $sformatf("rand_b%0d", k));
    end

    q = {};
    repeat (18) q.push_back(8'd1);
    model(q, 8, 4, ed, ec, eo);
    run_set(1'b1, q, ed, ec, eo, 0, 0, "sat_b");

    q = {};
    repeat (300) q.push_back(8'hFF);
    model(q, 16, 8, ed, ec, eo);
    run_set(1'b0, q, ed, ec, eo, 1, 0, "sat_a");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
